// File: rtl/pulse_det_pkg.sv
// Shared types and helpers for the multi-channel rising-edge count detector.
package pulse_det_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      COUNTING = 2'b01,
      ALERT    = 2'b10
   } det_state_e;

   // Legal when THRESH fits the counter and WINDOW fits the timer.
   function automatic bit det_params_ok(
      input int unsigned nch,
      input int unsigned cnt_w,
      input int unsigned thresh,
      input int unsigned window,
      input int unsigned win_w,
      input int unsigned sticky
   );
      return (nch >= 1) && (cnt_w >= 1) && (cnt_w < 32) &&
             (thresh >= 1) && (thresh <= (32'd1 << cnt_w) - 32'd1) &&
             (win_w >= 1) && (win_w < 32) && (window < (32'd1 << win_w)) &&
             (sticky <= 1);
   endfunction

endpackage

// File: rtl/pulse_det_channel.sv
// One detector channel: edge detect, count/window FSM, registered alert and count.
module pulse_det_channel
   import pulse_det_pkg::*;
#(
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned THRESH = 3,
   parameter int unsigned WINDOW = 0,
   parameter int unsigned WIN_W  = 8,
   parameter int unsigned STICKY = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             insig_i,
   input  logic             clear_i,
   output logic             alert_o,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] THR_M1   = CNT_W'(THRESH - 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);

   det_state_e       state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIN_W-1:0] timer_q;
   logic             prev_q;
   logic             alert_q;
   logic             rise;

   assign rise = insig_i & ~prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         timer_q <= '0;
         prev_q  <= 1'b0;
         alert_q <= 1'b0;
      end else begin
         prev_q <= insig_i;
         if (clear_i) begin
            state_q <= IDLE;
            count_q <= '0;
            timer_q <= '0;
            alert_q <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (rise) begin
                     count_q <= CNT_W'(1);
                     timer_q <= '0;
                     if (THRESH == 1) begin
                        state_q <= ALERT;
                        alert_q <= 1'b1;
                     end else begin
                        state_q <= COUNTING;
                     end
                  end
               end
               COUNTING: begin
                  if (rise) begin
                     count_q <= count_q + 1'b1;
                     timer_q <= '0;
                     if (count_q == THR_M1) begin
                        state_q <= ALERT;
                        alert_q <= 1'b1;
                     end
                  end else if ((WINDOW != 0) && (timer_q == WIN_LAST)) begin
                     state_q <= IDLE;
                     count_q <= '0;
                     timer_q <= '0;
                  end else begin
                     timer_q <= timer_q + 1'b1;
                  end
               end
               ALERT: begin
                  // One-shot mode re-arms here; a rise in this cycle starts a new count.
                  if (STICKY == 0) begin
                     timer_q <= '0;
                     if (rise && (THRESH == 1)) begin
                        count_q <= CNT_W'(1);
                     end else if (rise) begin
                        state_q <= COUNTING;
                        count_q <= CNT_W'(1);
                        alert_q <= 1'b0;
                     end else begin
                        state_q <= IDLE;
                        count_q <= '0;
                        alert_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  state_q <= IDLE;
                  count_q <= '0;
                  timer_q <= '0;
                  alert_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign alert_o = alert_q;
   assign count_o = count_q;

endmodule

// File: rtl/pulse_count_detector.sv
// Multi-channel rising-edge counter with per-channel alert and a registered any-alert summary.
module pulse_count_detector
   import pulse_det_pkg::*;
#(
   parameter int unsigned NCH    = 4,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned THRESH = 3,
   parameter int unsigned WINDOW = 0,
   parameter int unsigned WIN_W  = 8,
   parameter int unsigned STICKY = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       insig,
   input  logic [NCH-1:0]       clear,
   output logic [NCH-1:0]       alert,
   output logic [NCH*CNT_W-1:0] count,
   output logic                 any_alert
);

   logic any_alert_q;

   if (!det_params_ok(NCH, CNT_W, THRESH, WINDOW, WIN_W, STICKY)) begin : g_param_err
      $error("pulse_count_detector: illegal parameter combination");
   end

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      pulse_det_channel #(
         .CNT_W (CNT_W),
         .THRESH(THRESH),
         .WINDOW(WINDOW),
         .WIN_W (WIN_W),
         .STICKY(STICKY)
      ) u_ch (
         .clk    (clk),
         .rst_n  (reset),
         .insig_i(insig[g]),
         .clear_i(clear[g]),
         .alert_o(alert[g]),
         .count_o(count[g*CNT_W +: CNT_W])
      );
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         any_alert_q <= 1'b0;
      end else begin
         any_alert_q <= |alert;
      end
   end

   assign any_alert = any_alert_q;

endmodule

// File: tb/tb_pulse_count_detector.sv
// Directed and randomised checks of three detector configurations against hand values and a model.
module tb_pulse_count_detector;

   localparam int unsigned THR = 3;

   typedef struct packed {
      logic [3:0] cnt;
      logic [7:0] tmr;
      logic       alt;
   } ch_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  ins  [3];
   logic [3:0]  clr  [3];
   logic [3:0]  alt  [3];
   logic [15:0] cnt  [3];
   logic        anyo [3];

   ch_t         m_st   [3][4];
   logic [3:0]  m_prev [3];
   logic        m_any  [3];

   int unsigned total = 0;
   int unsigned bad   = 0;

   always #5 clk = ~clk;

   pulse_count_detector #(
      .NCH(4), .CNT_W(4), .THRESH(3), .WINDOW(0), .WIN_W(8), .STICKY(1)
   ) u_a (
      .clk(clk), .reset(reset), .insig(ins[0]), .clear(clr[0]),
      .alert(alt[0]), .count(cnt[0]), .any_alert(anyo[0])
   );

   pulse_count_detector #(
      .NCH(4), .CNT_W(4), .THRESH(3), .WINDOW(5), .WIN_W(8), .STICKY(1)
   ) u_b (
      .clk(clk), .reset(reset), .insig(ins[1]), .clear(clr[1]),
      .alert(alt[1]), .count(cnt[1]), .any_alert(anyo[1])
   );

   pulse_count_detector #(
      .NCH(4), .CNT_W(4), .THRESH(3), .WINDOW(0), .WIN_W(8), .STICKY(0)
   ) u_c (
      .clk(clk), .reset(reset), .insig(ins[2]), .clear(clr[2]),
      .alert(alt[2]), .count(cnt[2]), .any_alert(anyo[2])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] c4(input int d, input int ch);
      return 32'(cnt[d][ch*4 +: 4]);
   endfunction

   function automatic int unsigned win_of(input int d);
      return (d == 1) ? 5 : 0;
   endfunction

   function automatic bit sticky_of(input int d);
      return d != 2;
   endfunction

   function automatic ch_t nxt(input ch_t s, input logic r, input logic c,
                               input int unsigned win, input bit sticky);
      ch_t n;
      n = s;
      if (c) begin
         n = '0;
      end else if (s.alt) begin
         if (!sticky) begin
            n = '0;
            if (r) n.cnt = 4'd1;
         end
      end else if (r) begin
         n.cnt = s.cnt + 4'd1;
         n.tmr = '0;
         n.alt = (n.cnt == 4'(THR));
      end else if (s.cnt != 0) begin
         if ((win != 0) && (int'(s.tmr) + 1 == int'(win))) n = '0;
         else n.tmr = s.tmr + 8'd1;
      end
      return n;
   endfunction

   function automatic logic m_alt_or(input int d);
      logic o;
      o = 1'b0;
      for (int ch = 0; ch < 4; ch++) o = o | m_st[d][ch].alt;
      return o;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int d = 0; d < 3; d++) begin
            m_prev[d] <= '0;
            m_any[d]  <= 1'b0;
            for (int ch = 0; ch < 4; ch++) m_st[d][ch] <= '0;
         end
      end else begin
         for (int d = 0; d < 3; d++) begin
            m_prev[d] <= ins[d];
            m_any[d]  <= m_alt_or(d);
            for (int ch = 0; ch < 4; ch++)
               m_st[d][ch] <= nxt(m_st[d][ch], ins[d][ch] & ~m_prev[d][ch], clr[d][ch],
                                  win_of(d), sticky_of(d));
         end
      end
   end

   initial begin
      logic [15:0] ec;
      logic [3:0]  ea;
      for (int d = 0; d < 3; d++) begin
         ins[d] = '0;
         clr[d] = '0;
      end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int d = 0; d < 3; d++) begin
         check($sformatf("rst_cnt%0d", d), 32'(cnt[d]), 0);
         check($sformatf("rst_alt%0d", d), 32'(alt[d]), 0);
         check($sformatf("rst_any%0d", d), 32'(anyo[d]), 0);
      end

      // Sticky alert on ch0 after three pulses, released by clear.
      for (int c = 0; c < 22; c++) begin
         ins[0][0] = (c == 2) || (c == 5) || (c == 8) || (c == 12);
         clr[0][0] = (c == 20);
         tick();
         if (c == 2)  check("t1_cnt_c2", c4(0, 0), 1);
         if (c == 4)  check("t1_cnt_c4", c4(0, 0), 1);
         if (c == 5)  check("t1_cnt_c5", c4(0, 0), 2);
         if (c == 7)  check("t1_alt_c7", 32'(alt[0]), 0);
         if (c == 8)  check("t1_cnt_c8", c4(0, 0), 3);
         if (c == 8)  check("t1_alt_c8", 32'(alt[0]), 1);
         if (c == 8)  check("t1_any_c8", 32'(anyo[0]), 0);
         if (c == 9)  check("t1_any_c9", 32'(anyo[0]), 1);
         if (c == 12) check("t1_sat_c12", c4(0, 0), 3);
         if (c == 19) check("t1_alt_c19", 32'(alt[0]), 1);
         if (c == 20) check("t1_alt_c20", 32'(alt[0]), 0);
         if (c == 20) check("t1_cnt_c20", c4(0, 0), 0);
         if (c == 20) check("t1_any_c20", 32'(anyo[0]), 1);
         if (c == 21) check("t1_any_c21", 32'(anyo[0]), 0);
      end

      // Held-high input on ch1 counts once.
      for (int c = 0; c < 15; c++) begin
         ins[0][1] = (c < 10) || (c == 12);
         tick();
         if (c == 0)  check("t2_cnt_c0", c4(0, 1), 1);
         if (c == 9)  check("t2_cnt_c9", c4(0, 1), 1);
         if (c == 9)  check("t2_alt_c9", 32'(alt[0]), 0);
         if (c == 12) check("t2_cnt_c12", c4(0, 1), 2);
         if (c == 14) check("t2_cnt0_c14", c4(0, 0), 0);
      end

      // Inactivity window discards the partial count on ch2.
      for (int c = 0; c < 12; c++) begin
         ins[1][2] = (c == 0) || (c == 3) || (c == 10);
         tick();
         if (c == 3)  check("t3_cnt_c3", c4(1, 2), 2);
         if (c == 7)  check("t3_cnt_c7", c4(1, 2), 2);
         if (c == 8)  check("t3_cnt_c8", c4(1, 2), 0);
         if (c == 10) check("t3_cnt_c10", c4(1, 2), 1);
      end

      // One-shot alert on ch3.
      for (int c = 0; c < 8; c++) begin
         ins[2][3] = (c < 7) && (c % 2 == 0);
         tick();
         if (c == 3) check("t4_cnt_c3", c4(2, 3), 2);
         if (c == 3) check("t4_alt_c3", 32'(alt[2]), 0);
         if (c == 4) check("t4_cnt_c4", c4(2, 3), 3);
         if (c == 4) check("t4_alt_c4", 32'(alt[2]), 32'h8);
         if (c == 5) check("t4_cnt_c5", c4(2, 3), 0);
         if (c == 5) check("t4_alt_c5", 32'(alt[2]), 0);
         if (c == 5) check("t4_any_c5", 32'(anyo[2]), 1);
         if (c == 6) check("t4_cnt_c6", c4(2, 3), 1);
         if (c == 6) check("t4_any_c6", 32'(anyo[2]), 0);
         if (c == 7) check("t4_cnt_c7", c4(2, 3), 1);
      end

      // Clear beats a coincident rise; then asynchronous reset mid-cycle.
      for (int c = 0; c < 6; c++) begin
         ins[0][0] = (c == 0) || (c == 2) || (c >= 4);
         clr[0][0] = (c == 4);
         ins[0][3] = (c == 0) || (c == 2) || (c == 4);
         tick();
         if (c == 2) check("t5_cnt_c2", c4(0, 0), 2);
         if (c == 4) check("t5_cnt_c4", c4(0, 0), 0);
         if (c == 4) check("t5_alt3_c4", 32'(alt[0]), 32'h8);
         if (c == 5) check("t5_held_c5", c4(0, 0), 0);
      end
      check("t5_cnt1_pre", c4(0, 1), 2);
      check("t5_any_pre", 32'(anyo[0]), 1);
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_cnt_a", 32'(cnt[0]), 0);
      check("t5_rst_alt_a", 32'(alt[0]), 0);
      check("t5_rst_any_a", 32'(anyo[0]), 0);
      check("t5_rst_cnt_b", 32'(cnt[1]), 0);
      check("t5_rst_cnt_c", 32'(cnt[2]), 0);
      for (int d = 0; d < 3; d++) begin
         ins[d] = '0;
         clr[d] = '0;
      end
      @(negedge clk);
      reset = 1'b1;

      // Random toggling and occasional clears on every channel of every configuration.
      for (int c = 0; c < 300; c++) begin
         for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
               if ($urandom_range(0, 3) == 0) ins[d][ch] = ~ins[d][ch];
               clr[d][ch] = ($urandom_range(0, 31) == 0);
            end
         end
         tick();
         for (int d = 0; d < 3; d++) begin
            for (int ch = 0; ch < 4; ch++) begin
               ec[ch*4 +: 4] = m_st[d][ch].cnt;
               ea[ch]        = m_st[d][ch].alt;
            end
            check($sformatf("rnd_cnt%0d_c%0d", d, c), 32'(cnt[d]), 32'(ec));
            check($sformatf("rnd_alt%0d_c%0d", d, c), 32'(alt[d]), 32'(ea));
            check($sformatf("rnd_any%0d_c%0d", d, c), 32'(anyo[d]), 32'(m_any[d]));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
